// File: rtl/data_mem_responder.sv
// Data-memory responder: word RAM below MMIO_BASE plus a register page holding
// GPIO, a compare timer with interrupt and a write-access counter.
module data_mem_responder #(
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MMIO_BASE = 'hF00,
  parameter int unsigned GPIO_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] data_mem_in,
  output logic [DATA_W-1:0] data_mem_out,
  output logic [GPIO_W-1:0] gpio_out,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic              irq
);

  localparam logic [ADDR_W-1:0] BASE          = ADDR_W'(MMIO_BASE);
  localparam logic [ADDR_W-1:0] OFF_GPIO_OUT  = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] OFF_GPIO_IN   = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] OFF_TIMER_CNT = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] OFF_TIMER_CMP = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] OFF_TIMER_CTL = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] OFF_STATUS    = ADDR_W'(5);
  localparam logic [ADDR_W-1:0] OFF_WR_COUNT  = ADDR_W'(6);

  logic [DATA_W-1:0] ram [MMIO_BASE];

  logic              is_ram;
  logic [ADDR_W-1:0] offset;
  logic              mmio_wr;
  logic              wr_gpio, wr_cnt, wr_cmp, wr_ctl, wr_status, wr_wrcount;

  logic [GPIO_W-1:0] gpio_sync1, gpio_sync2;
  logic [DATA_W-1:0] timer_cnt, timer_cmp;
  logic [2:0]        timer_ctl;
  logic              match_flag;
  logic [DATA_W-1:0] wr_count;

  logic              timer_match;
  logic [DATA_W-1:0] timer_cnt_next;
  logic              match_flag_next;
  logic [DATA_W-1:0] wr_count_next;

  assign is_ram     = ram_addr < BASE;
  assign offset     = ram_addr - BASE;
  assign mmio_wr    = mem_wr && !is_ram;
  assign wr_gpio    = mmio_wr && (offset == OFF_GPIO_OUT);
  assign wr_cnt     = mmio_wr && (offset == OFF_TIMER_CNT);
  assign wr_cmp     = mmio_wr && (offset == OFF_TIMER_CMP);
  assign wr_ctl     = mmio_wr && (offset == OFF_TIMER_CTL);
  assign wr_status  = mmio_wr && (offset == OFF_STATUS);
  assign wr_wrcount = mmio_wr && (offset == OFF_WR_COUNT);

  // RAM is not reset; a write presented while reset is asserted is dropped.
  always_ff @(posedge clk) begin
    if (reset && mem_wr && is_ram) ram[ram_addr] <= data_mem_in;
  end

  assign timer_match = timer_ctl[0] && (timer_cnt == timer_cmp);

  // CPU count write overrides increment/reload; a match wins over a W1C clear.
  always_comb begin
    timer_cnt_next = timer_cnt;
    if (timer_ctl[0])
      timer_cnt_next = (timer_match && timer_ctl[1]) ? '0 : timer_cnt + DATA_W'(1);
    if (wr_cnt) timer_cnt_next = data_mem_in;

    match_flag_next = match_flag;
    if (wr_status && data_mem_in[0]) match_flag_next = 1'b0;
    if (timer_match) match_flag_next = 1'b1;

    wr_count_next = wr_count;
    if (mem_wr) begin
      if (wr_wrcount)           wr_count_next = '0;
      else if (wr_count != '1)  wr_count_next = wr_count + DATA_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gpio_out   <= '0;
      gpio_sync1 <= '0;
      gpio_sync2 <= '0;
      timer_cnt  <= '0;
      timer_cmp  <= '0;
      timer_ctl  <= '0;
      match_flag <= 1'b0;
      wr_count   <= '0;
      irq        <= 1'b0;
    end else begin
      gpio_sync1 <= gpio_in;
      gpio_sync2 <= gpio_sync1;
      if (wr_gpio) gpio_out  <= data_mem_in[GPIO_W-1:0];
      if (wr_cmp)  timer_cmp <= data_mem_in;
      if (wr_ctl)  timer_ctl <= data_mem_in[2:0];
      timer_cnt  <= timer_cnt_next;
      match_flag <= match_flag_next;
      wr_count   <= wr_count_next;
      irq        <= match_flag & timer_ctl[2];
    end
  end

  always_comb begin
    data_mem_out = '0;
    if (mem_rd) begin
      if (is_ram) begin
        data_mem_out = ram[ram_addr];
      end else begin
        case (offset)
          OFF_GPIO_OUT:  data_mem_out = DATA_W'(gpio_out);
          OFF_GPIO_IN:   data_mem_out = DATA_W'(gpio_sync2);
          OFF_TIMER_CNT: data_mem_out = timer_cnt;
          OFF_TIMER_CMP: data_mem_out = timer_cmp;
          OFF_TIMER_CTL: data_mem_out = DATA_W'(timer_ctl);
          OFF_STATUS:    data_mem_out = DATA_W'(match_flag);
          OFF_WR_COUNT:  data_mem_out = wr_count;
          default:       data_mem_out = '0;
        endcase
      end
    end
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Responder end of the CPU data-memory interface.
- Accepts the CPU's `mem_rd`/`mem_wr`/`ram_addr`/`data_mem_in` requests and returns `data_mem_out`.
- Backs a word-addressed RAM region and a small memory-mapped I/O page: GPIO, a timer with compare/interrupt, and a write-access counter.
- Sits beside the cpu top; no stall path exists, so every access completes in the request cycle.

Parameters:
ADDR_W, 12, word address width (matches `ram_addr`)
DATA_W, 32, data word width
MMIO_BASE, 12'hF00, first MMIO address; RAM occupies 0 .. MMIO_BASE-1 (3840 words)
GPIO_W, 8, GPIO output/input width

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
mem_rd  in  1  read request, current cycle
mem_wr  in  1  write request, committed at next rising edge
ram_addr  in  ADDR_W  word address
data_mem_in  in  DATA_W  write data
data_mem_out  out  DATA_W  read data, combinational from address/state
gpio_out  out  GPIO_W  GPIO output register
gpio_in  in  GPIO_W  asynchronous external inputs
irq  out  1  timer interrupt, registered

Behaviour:
- Reset (reset=0, async):
  - gpio_out=0, timer count=0, cmp=0, ctrl=0, status=0, access count=0, GPIO synchroniser flops=0, irq=0.
  - RAM contents are not reset.
- Read:
  - data_mem_out is valid in the same cycle as mem_rd=1 (zero-latency combinational read).
  - mem_rd=0 -> data_mem_out=0.
- Write: mem_wr=1 -> RAM word or MMIO register updates at the rising edge.
- mem_rd and mem_wr together, same address: data_mem_out shows pre-write contents; the write commits at the edge.
- MMIO map (offset from MMIO_BASE); unmapped offsets read 0, writes ignored:
  - 0x00 GPIO_OUT RW: low GPIO_W bits; upper bits read 0.
  - 0x01 GPIO_IN RO: gpio_in through a 2-flop synchroniser, so 2-cycle latency to visibility.
  - 0x02 TIMER_COUNT RW.
  - 0x03 TIMER_CMP RW.
  - 0x04 TIMER_CTRL RW: bit0 enable, bit1 auto-reload, bit2 irq enable; other bits read 0.
  - 0x05 STATUS: bit0 match flag, sticky; writing 1 to bit0 clears it.
  - 0x06 WR_COUNT: counts every accepted mem_wr (RAM or MMIO); saturates at 0xFFFFFFFF; any write to it clears it to 0, and that write is not counted.
- Timer, each edge with enable=1:
  - Compare is evaluated on the pre-edge value.
  - count==cmp and auto-reload=1 -> count<=0; otherwise count<=count+1, wrapping 0xFFFFFFFF -> 0.
  - count==cmp -> match flag<=1.
  - enable=0 -> count holds, no match detection.
- Precedence and simultaneous events:
  - CPU write to TIMER_COUNT beats increment/reload.
  - Match set beats a W1C clear in the same cycle; the flag stays 1.
  - A write to TIMER_CMP takes effect on the following edge's compare.
- irq <= match flag & ctrl bit2, registered: asserts one cycle after the flag sets and drops one cycle after the flag clears.
- Reset mid-operation: all MMIO state returns to reset values immediately; an in-flight write is lost.

Test Plan:
- RAM write/read: write 0xDEADBEEF @0x010, next cycle mem_rd @0x010 -> data_mem_out=0xDEADBEEF; mem_rd=0 -> 0.
- RAM collision: @0x020 holds 0x1, same-cycle rd+wr 0x2 -> data_mem_out=0x1 that cycle, 0x2 next read; write @0xF07 -> reads 0, WR_COUNT still increments.
- Timer reload/irq: cmp=3, ctrl=0b111 -> count 0,1,2,3,0,...; flag=1 after edge where count=3; irq=1 one cycle later; write 1 to STATUS -> flag 0, irq 0 next cycle.
- Timer wrap and precedence: count=0xFFFFFFFF, enable, cmp=5, no reload -> 0; write 0x100 to TIMER_COUNT while enabled -> reads 0x100 next cycle, not 0x101.
- GPIO: write 0x1A5 to GPIO_OUT -> gpio_out=0xA5, read back 0xA5; gpio_in=0x3C -> GPIO_IN reads 0x3C on the second edge after the change, not the first.
- Async reset: assert reset mid-count (count=0x40, flag=1, WR_COUNT=7) without a clock edge -> all MMIO regs 0, irq=0; a RAM word written before reset still reads its old value.
